multicycle_controller: RTL

- Moore FSM that sequences a shared-resource multi-cycle RV32I datapath: one memory for instructions and data, one ALU for PC+4, branch target and execute.
- Sits beside the datapath in place of the single-cycle decode path.
- Drives mux selects, register enables and ALU control per state.
- Handles a memory-ready handshake with timeout.
- Traps on illegal opcodes.

---
 rtl/rv_ctrl_pkg.sv | 71 +++++++
 rtl/alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes, ALU codes, mux selects, trap causes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Immediate format depends only on the opcode, so it is decoded outside the FSM.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode from ALUOp and IR fields; flags unsupported funct3 when ALUOp selects funct.
// Latency: combinational.
// Backpressure: none.
// Ports: alu_op, funct3, op5 (IR[5]), funct7b5 (IR[30]) in; alu_control, illegal out.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // sub only for R-type with funct7[5]; addi ignores IR[30]
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    // unsupported funct3 leaves the ALU on add; the FSM traps next edge
                    default: illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore controller for a shared-memory multicycle RV32I datapath; drives selects, enables and ALU control per state.
// Latency: lw 5, sw/ALU/jal 4, beq 3 cycles, plus one per memory wait cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold on mem_ready=0; trap after MEM_TIMEOUT waits (0 = never).
// Ports: clk, reset_n (sync, active-low); IR fields op/funct3/funct7b5, zero, mem_ready in;
//        datapath controls, sticky trap/trap_cause and debug state_o out.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_o
);

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             trap_q;
    logic [1:0]       trap_cause_q, cause_next;
    alu_op_t          alu_op;
    logic             illegal_funct;
    logic             pc_update, branch;
    logic             ir_write_raw, mem_write_raw, reg_write_raw;
    logic             waiting, timed_out;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control),
        .illegal     (illegal_funct)
    );

    assign waiting = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE)) && !mem_ready;
    // The wait that would bring the count up to MEM_TIMEOUT is the last one allowed;
    // mem_ready in that same cycle takes the normal path because waiting is then low.
    assign timed_out = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_next    = state;
        cause_next    = CAUSE_NONE;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        alu_op        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_update    = 1'b1;
                    state_next   = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                alu_op    = ALUOP_FUNCT;
                if (illegal_funct) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_next    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RD1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_FETCH;
            wait_cnt     <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state <= state_next;
            // Any state change clears the counter, which covers entry into every memory state.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if ((state_next == S_TRAP) && (state != S_TRAP)) begin
                trap_q       <= 1'b1;
                trap_cause_q <= cause_next;
            end
        end
    end

    // Write enables are masked while reset is held so an abandoned instruction commits nothing.
    assign pc_write   = reset_n & (pc_update | (branch & zero));
    assign ir_write   = reset_n & ir_write_raw;
    assign mem_write  = reset_n & mem_write_raw;
    assign reg_write  = reset_n & reg_write_raw;
    assign imm_src    = imm_src_of(op);
    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;
    assign state_o    = state;

endmodule
